// File: rtl/seq_count_pkg.sv
// Shared FSM encodings and a constant-width helper for the pair-count arbiter.
package seq_count_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Ceiling log2, usable in constant expressions (port and localparam widths).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requesting channel at or after last_grant+1.
module rr_arbiter
  import seq_count_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]        req,
  input  logic [clog2(NUM_CH)-1:0] last_grant,
  output logic [NUM_CH-1:0]        grant_c,
  output logic [clog2(NUM_CH)-1:0] index_c,
  output logic                     any_c
);

  localparam int unsigned CH_W = clog2(NUM_CH);

  // Scan farthest-to-nearest so the nearest requester after last_grant wins.
  always_comb begin
    int unsigned cand;
    cand    = 0;
    grant_c = '0;
    index_c = '0;
    any_c   = 1'b0;
    for (int unsigned off = NUM_CH; off >= 1; off--) begin
      cand = (32'(last_grant) + off) % NUM_CH;
      if (req[CH_W'(cand)]) begin
        grant_c               = '0;
        grant_c[CH_W'(cand)]  = 1'b1;
        index_c               = CH_W'(cand);
        any_c                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_count_arbiter.sv
// Shares one serial "11"-pair counter between NUM_CH word requesters.
module seq_count_arbiter
  import seq_count_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH*DATA_W-1:0]   req_data,
  output logic [NUM_CH-1:0]          req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [clog2(NUM_CH)-1:0]   res_ch,
  output logic [CNT_W-1:0]           res_count,
  output logic                       busy
);

  localparam int unsigned CH_W = clog2(NUM_CH);
  localparam int unsigned BI_W = clog2(DATA_W);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [DATA_W-1:0] word;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   last_grant;
  logic [CNT_W-1:0]  count;
  logic              prev_bit;
  logic [BI_W-1:0]   bit_idx;

  logic [NUM_CH-1:0] grant_c;
  logic [CH_W-1:0]   grant_idx_c;
  logic              grant_any_c;
  logic              accept_c;
  logic [DATA_W-1:0] sel_word_c;
  logic              bit_c;
  logic [CNT_W-1:0]  count_next_c;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant_c    (grant_c),
    .index_c    (grant_idx_c),
    .any_c      (grant_any_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and the accept strobe; no accept while reset is asserted.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_any_c && reset) begin
          accept_c   = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: if (bit_idx == '0) state_next = ST_DONE;
      ST_DONE:  if (res_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign req_ready = accept_c ? grant_c : '0;

  // Granted channel's word, plus the current serial bit and saturating count.
  always_comb begin
    sel_word_c   = DATA_W'(req_data >> (32'(grant_idx_c) * DATA_W));
    bit_c        = word[DATA_W-1];
    count_next_c = count;
    if (bit_c && prev_bit && (count != {CNT_W{1'b1}}))
      count_next_c = count + CNT_W'(1);
  end

  // Datapath: latch on accept, shift MSB-first, publish and hold the result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word       <= '0;
      cur_ch     <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      count      <= '0;
      prev_bit   <= 1'b0;
      bit_idx    <= '0;
      res_valid  <= 1'b0;
      res_ch     <= '0;
      res_count  <= '0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      if (accept_c) begin
        word       <= sel_word_c;
        cur_ch     <= grant_idx_c;
        last_grant <= grant_idx_c;
        count      <= '0;
        prev_bit   <= 1'b0;
        bit_idx    <= BI_W'(DATA_W - 1);
      end
      if (state == ST_SHIFT) begin
        word     <= word << 1;
        prev_bit <= bit_c;
        count    <= count_next_c;
        bit_idx  <= bit_idx - BI_W'(1);
        if (bit_idx == '0) begin
          res_valid <= 1'b1;
          res_ch    <= cur_ch;
          res_count <= count_next_c;
        end
      end
      if ((state == ST_DONE) && res_ready) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_count_arbiter.sv
// Directed plus randomized bench for seq_count_arbiter against a behavioural model.
module tb_seq_count_arbiter;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic [NUM_CH-1:0]        req_ready, req_ready2;
  logic                     res_valid, res_valid2;
  logic                     res_ready;
  logic [1:0]               res_ch, res_ch2;
  logic [3:0]               res_count;
  logic [1:0]               res_count2;
  logic                     busy, busy2;

  seq_count_arbiter #(.NUM_CH(4), .DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_ch(res_ch), .res_count(res_count), .busy(busy)
  );

  seq_count_arbiter #(.NUM_CH(4), .DATA_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready2), .res_valid(res_valid2), .res_ready(res_ready),
    .res_ch(res_ch2), .res_count(res_count2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int checks;
  int errors;
  logic [NUM_CH-1:0] vld;
  logic [DATA_W-1:0] words [NUM_CH];
  int last_g;
  logic [7:0] t3w [4];
  int t3e [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    req_valid = vld;
    for (int i = 0; i < NUM_CH; i++) req_data[i*DATA_W +: DATA_W] = words[i];
    #1;
  endtask

  // Round-robin choice: first valid channel after the last grant.
  function automatic int pick(input logic [NUM_CH-1:0] v, input int lg);
    for (int k = 1; k <= NUM_CH; k++)
      if (v[(lg + k) % NUM_CH]) return (lg + k) % NUM_CH;
    return -1;
  endfunction

  // Number of adjacent "11" pairs in the word, clipped at maxc.
  function automatic int pairs(input logic [DATA_W-1:0] w, input int maxc);
    int n;
    n = 0;
    for (int i = 0; i < DATA_W - 1; i++) if (w[i] && w[i+1]) n++;
    return (n > maxc) ? maxc : n;
  endfunction

  // One full transaction from the IDLE cycle of the grant to the IDLE after the result.
  task automatic txn(input int hold, input bit add_mid, output int g_o, output int c_o, output int c2_o);
    int g;
    logic [DATA_W-1:0] w;
    int e4, e2;
    g = pick(vld, last_g);
    g_o = g; c_o = -1; c2_o = -1;
    if (g < 0) begin
      check("txn_has_request", 32'(vld), 32'hFFFF_FFFF);
      return;
    end
    w  = words[g];
    e4 = pairs(w, 15);
    e2 = pairs(w, 3);
    check("grant_onehot", 32'(req_ready), 32'(1) << g);
    check("grant_onehot2", 32'(req_ready2), 32'(1) << g);
    check("busy_idle", 32'(busy), 0);
    res_ready = (hold == 0);
    tick();
    last_g = g;
    vld[g] = 1'b0;
    apply();
    for (int c = 0; c < DATA_W; c++) begin
      check("shift_res_valid", 32'(res_valid), 0);
      check("shift_busy", 32'(busy), 1);
      check("shift_ready", 32'(req_ready), 0);
      if (add_mid && c == 3) begin
        int n;
        n = $urandom_range(0, NUM_CH - 1);
        if (!vld[n] && n != g) begin
          vld[n] = 1'b1;
          words[n] = 8'($urandom);
          apply();
        end
      end
      tick();
    end
    check("res_valid", 32'(res_valid), 1);
    check("res_ch", 32'(res_ch), 32'(g));
    check("res_count", 32'(res_count), 32'(e4));
    check("res_valid2", 32'(res_valid2), 1);
    check("res_ch2", 32'(res_ch2), 32'(g));
    check("res_count_sat", 32'(res_count2), 32'(e2));
    c_o  = int'(res_count);
    c2_o = int'(res_count2);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 32'(res_valid), 1);
      check("hold_ch", 32'(res_ch), 32'(g));
      check("hold_count", 32'(res_count), 32'(e4));
      check("hold_busy", 32'(busy), 1);
      check("hold_ready", 32'(req_ready), 0);
    end
    res_ready = 1'b1;
    tick();
    check("release_valid", 32'(res_valid), 0);
    check("release_busy", 32'(busy2), 0);
    check("release_ch_kept", 32'(res_ch), 32'(g));
  endtask

  initial begin
    int g, c, c2;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    res_ready = 1'b0;
    vld = '0;
    for (int i = 0; i < NUM_CH; i++) words[i] = '0;
    apply();
    last_g = NUM_CH - 1;

    // Reset held three cycles.
    repeat (3) tick();
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_res_count", 32'(res_count), 0);
    check("rst_res_ch", 32'(res_ch), 0);
    reset = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 0);

    // Single word on ch0.
    words[0] = 8'b1110_1101;
    vld = 4'b0001;
    apply();
    txn(0, 1'b0, g, c, c2);
    check("t2_ch", 32'(g), 0);
    check("t2_count", 32'(c), 3);

    // Value table on ch1, including saturation in the narrow instance.
    t3w = '{8'hFF, 8'h00, 8'hAA, 8'h81};
    t3e = '{7, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      words[1] = t3w[k];
      vld = 4'b0010;
      apply();
      txn(0, 1'b0, g, c, c2);
      check("t3_ch", 32'(g), 1);
      check("t3_count", 32'(c), 32'(t3e[k]));
      if (k == 0) check("t3_sat", 32'(c2), 3);
    end

    // All channels valid right after reset -> 0,1,2,3; then ch2+ch0 -> 0,2.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    last_g = NUM_CH - 1;
    vld = 4'hF;
    for (int i = 0; i < NUM_CH; i++) words[i] = 8'($urandom);
    apply();
    for (int k = 0; k < NUM_CH; k++) begin
      txn(0, 1'b0, g, c, c2);
      check("t4_order", 32'(g), 32'(k));
    end
    words[0] = 8'h3C;
    words[2] = 8'hE7;
    vld = 4'b0101;
    apply();
    txn(0, 1'b0, g, c, c2);
    check("t4_first", 32'(g), 0);
    txn(0, 1'b0, g, c, c2);
    check("t4_second", 32'(g), 2);

    // Backpressure held five cycles in DONE.
    words[0] = 8'hF0;
    vld = 4'b0001;
    apply();
    txn(5, 1'b0, g, c, c2);
    check("t5_count", 32'(c), 3);

    // Reset in the middle of a ch1 word; ch1 stays valid and is re-granted first.
    words[1] = 8'hFF;
    vld = 4'b0010;
    apply();
    check("t6_grant", 32'(req_ready), 32'b0010);
    tick();
    repeat (3) begin
      check("t6_shift_ready", 32'(req_ready), 0);
      check("t6_shift_busy", 32'(busy), 1);
      tick();
    end
    reset = 1'b0;
    tick();
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_valid", 32'(res_valid), 0);
    check("t6_rst_ready", 32'(req_ready), 0);
    check("t6_rst_count", 32'(res_count), 0);
    reset = 1'b1;
    #1;
    last_g = NUM_CH - 1;
    txn(0, 1'b0, g, c, c2);
    check("t6_regrant", 32'(g), 1);
    check("t6_count", 32'(c), 7);

    // Randomized traffic: random sets, drops before grant, late arrivals, backpressure.
    for (int it = 0; it < 40; it++) begin
      if (vld == '0) begin
        vld = 4'($urandom_range(1, 15));
        for (int i = 0; i < NUM_CH; i++) if (vld[i]) words[i] = 8'($urandom);
        apply();
      end else if ($countones(vld) > 1 && $urandom_range(0, 3) == 0) begin
        int d;
        d = $urandom_range(0, NUM_CH - 1);
        if (vld[d]) vld[d] = 1'b0;
        apply();
      end
      txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), g, c, c2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
